// File: rtl/rng_core.sv
// rng_core: 16-bit Galois LFSR random byte source for the CHIP-8 CXNN instruction.
// Ports: clk, rst (sync, active-high), en (advance), seed_load/seed_in (reseed),
//        x (random byte = state[7:0]), state (full LFSR state).
// Optional: define RNG_ENTROPY_EN to add an 8-bit entropy input mixed into state[15:8] on steps.
module rng_core #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          STEPS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
`ifdef RNG_ENTROPY_EN
  input  logic [7:0]  entropy,
`endif
  output logic [7:0]  x,
  output logic [15:0] state
);
  localparam logic [15:0] FALLBACK = 16'hACE1;
  localparam logic [15:0] EFF_SEED = (SEED == 16'h0) ? FALLBACK : SEED;
  if (STEPS < 1 || STEPS > 16) begin : g_bad_steps
    $error("rng_core: STEPS must be in 1..16");
  end
  logic [15:0] state_q, state_d, step_s;
  always_comb begin
    step_s = state_q;
    for (int i = 0; i < STEPS; i++)
      step_s = (step_s >> 1) ^ (step_s[0] ? 16'hB400 : 16'h0000);
`ifdef RNG_ENTROPY_EN
    // entropy could cancel the state to zero, which would lock the LFSR
    step_s = step_s ^ {entropy, 8'h00};
    step_s = (step_s == 16'h0) ? FALLBACK : step_s;
`endif
    state_d = seed_load ? ((seed_in == 16'h0) ? FALLBACK : seed_in) :
              en        ? step_s : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= EFF_SEED;
    else     state_q <= state_d;
  end
  assign state = state_q;
  assign x     = state_q[7:0];
endmodule

// File: tb/tb_rng_core.sv
// tb_rng_core: scoreboard bench for rng_core with STEPS=1 and STEPS=8 instances.
module tb_rng_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0, en = 1'b0, seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0;
  logic [7:0]  entropy = 8'h0;
  logic [7:0]  x1, x8;
  logic [15:0] state1, state8;
  logic [15:0] m1, m8;
  int          n_tests = 0, n_fail = 0;
  typedef struct { logic [15:0] s1; logic [15:0] s8; } exp_t;
  exp_t        sb[$];
  always #5 clk = ~clk;
  rng_core #(.SEED(16'hACE1), .STEPS(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
`ifdef RNG_ENTROPY_EN
    .entropy(entropy),
`endif
    .x(x1), .state(state1));
  rng_core #(.SEED(16'hACE1), .STEPS(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
`ifdef RNG_ENTROPY_EN
    .entropy(entropy),
`endif
    .x(x8), .state(state8));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] lfsr1(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction
  function automatic logic [15:0] model(input logic [15:0] s, input int n, input bit r,
      input bit sl, input logic [15:0] si, input bit e, input logic [7:0] ent);
    logic [15:0] t;
    if (r) return 16'hACE1;
    if (sl) return (si == 16'h0) ? 16'hACE1 : si;
    if (!e) return s;
    t = s;
    for (int k = 0; k < n; k++) t = lfsr1(t);
`ifdef RNG_ENTROPY_EN
    t = t ^ {ent, 8'h00};
    if (t == 16'h0) t = 16'hACE1;
`endif
    return t;
  endfunction
  task automatic cyc(input bit r, input bit sl, input logic [15:0] si, input bit e,
      input logic [7:0] ent);
    exp_t ex;
    @(negedge clk);
    rst = r; seed_load = sl; seed_in = si; en = e; entropy = ent;
    m1 = model(m1, 1, r, sl, si, e, ent);
    m8 = model(m8, 8, r, sl, si, e, ent);
    sb.push_back('{s1: m1, s8: m8});
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    check("state1", {16'h0, state1}, {16'h0, ex.s1});
    check("x1", {24'h0, x1}, {24'h0, ex.s1[7:0]});
    check("state8", {16'h0, state8}, {16'h0, ex.s8});
    check("x8", {24'h0, x8}, {24'h0, ex.s8[7:0]});
  endtask
  initial begin
    int first_ret, zeros;
    logic [15:0] r8;
    m1 = 16'h0; m8 = 16'h0;
    cyc(1, 0, 16'h0, 0, 8'h0);
    check("rst_state", {16'h0, state1}, 32'hACE1);
    check("rst_x", {24'h0, x1}, 32'hE1);
    cyc(0, 0, 16'h0, 1, 8'h0);
    check("step1", {16'h0, state1}, 32'hE270);
    check("step1_x", {24'h0, x1}, 32'h70);
    r8 = 16'hACE1;
    for (int k = 0; k < 8; k++) r8 = lfsr1(r8);
    check("steps8", {16'h0, state8}, {16'h0, r8});
    cyc(0, 0, 16'h0, 1, 8'h0);
    check("step2", {16'h0, state1}, 32'h7138);
    check("step2_x", {24'h0, x1}, 32'h38);
    cyc(0, 0, 16'h0, 1, 8'h0);
    check("step3", {16'h0, state1}, 32'h389C);
    check("step3_x", {24'h0, x1}, 32'h9C);
    cyc(0, 1, 16'h0000, 1, 8'h0);
    check("load_zero", {16'h0, state1}, 32'hACE1);
    cyc(0, 1, 16'h1234, 1, 8'h0);
    check("load_1234", {16'h0, state1}, 32'h1234);
    cyc(1, 0, 16'h0, 0, 8'h0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 16'h0, 0, 8'h0);
    check("hold", {16'h0, state1}, 32'hACE1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 16'h0, 1, 8'h0);
    cyc(1, 1, 16'h1234, 1, 8'h0);
    check("rst_prio", {16'h0, state1}, 32'hACE1);
    for (int k = 0; k < 40; k++)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
          ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), $urandom_range(0, 1) == 1,
          8'($urandom));
`ifdef RNG_ENTROPY_EN
    cyc(1, 0, 16'h0, 0, 8'h0);
    cyc(0, 0, 16'h0, 1, 8'hFF);
    check("entropy", {16'h0, state1}, 32'h1D70);
    cyc(0, 0, 16'h0, 0, 8'hAA);
    check("entropy_idle", {16'h0, state1}, 32'h1D70);
`endif
    cyc(1, 0, 16'h0, 0, 8'h0);
    first_ret = 0; zeros = 0;
    @(negedge clk);
    en = 1'b1; entropy = 8'h0; seed_load = 1'b0; rst = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      @(posedge clk);
      #1;
      if (state1 == 16'h0) zeros++;
      if (state1 == 16'hACE1 && first_ret == 0) first_ret = i;
    end
    check("period", first_ret, 65535);
    check("never_zero", zeros, 0);
    m1 = state1 == 16'hACE1 ? 16'hACE1 : 16'h0;
    cyc(1, 0, 16'h0, 1, 8'h0);
    check("mid_rst", {16'h0, state1}, 32'hACE1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
